// File: rtl/gp_outpad_word_driver_pkg.sv
// Shared types and defaults for the general-purpose outpad word driver.
// Imported by the top level and the bench.
package gp_outpad_pkg;

  localparam int DEF_NUM_PADS   = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef logic [DEF_NUM_PADS-1:0] pad_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } drv_state_e;

endpackage

// File: rtl/gp_outpad_word_driver_if.sv
// Pad-word input stream.
// valid/ready: a word transfers on a rising clk edge where in_valid and
// in_ready are both high; in_data must stay stable while in_valid=1 and in_ready=0.
interface gp_outpad_word_driver_if #(
  parameter int NUM_PADS = 8
) ();

  logic                in_valid;
  logic                in_ready;
  logic [NUM_PADS-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/gp_outpad_word_driver_fifo.sv
// Synchronous circular-buffer FIFO for pad words.
// DEPTH must be a power of two so the pointers wrap on their own.
module gp_outpad_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/gp_outpad_word_driver.sv
// Drives buffered pad words onto the bottom-side outpad tile pins, holding each
// for hold_cycles+1 cycles, and falls back to idle_value when no word is active.
module gp_outpad_word_driver
  import gp_outpad_pkg::*;
#(
  parameter int NUM_PADS   = DEF_NUM_PADS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int HOLD_W     = 8,
  parameter int UNDERRUN_W = 8,
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  gp_outpad_word_driver_if.slave  in_if,
  input  logic [HOLD_W-1:0]       hold_cycles,
  input  logic [NUM_PADS-1:0]     idle_value,
  output logic [NUM_PADS-1:0]     pin_outpad,
  output logic                    busy,
  output logic [CW-1:0]           fifo_count,
  output logic [UNDERRUN_W-1:0]   underrun_cnt,
  output drv_state_e              dbg_state
);

  drv_state_e            r_state;
  drv_state_e            w_next_state;
  logic                  r_ready_en;
  logic [HOLD_W-1:0]     r_cnt;
  logic [NUM_PADS-1:0]   r_pin;
  logic [UNDERRUN_W-1:0] r_underrun;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_underrun_inc;
  logic                  w_full;
  logic                  w_empty;
  logic [NUM_PADS-1:0]   w_head;

  // r_ready_en keeps in_ready low through reset and lets it rise one edge later.
  assign in_if.in_ready = r_ready_en & ~w_full;
  assign w_push         = in_if.in_valid & in_if.in_ready;

  gp_outpad_word_fifo #(
    .WIDTH (NUM_PADS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (in_if.in_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .count     (fifo_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_pop          = 1'b0;
    w_underrun_inc = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && !w_empty) begin
          w_pop        = 1'b1;
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        if (r_cnt != '0) begin
          w_next_state = HOLD;
        end else if (enable && !w_empty) begin
          w_pop        = 1'b1;
          w_next_state = HOLD;
        end else begin
          w_next_state   = IDLE;
          w_underrun_inc = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ready_en <= 1'b0;
      r_pin      <= '0;
      r_cnt      <= '0;
      r_underrun <= '0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_pop) begin
        r_pin <= w_head;
        r_cnt <= hold_cycles;
      end else if (r_state == HOLD && r_cnt != '0) begin
        r_cnt <= r_cnt - HOLD_W'(1);
      end else if (w_next_state == IDLE) begin
        r_pin <= idle_value;
      end
      if (w_underrun_inc && r_underrun != '1) begin
        r_underrun <= r_underrun + UNDERRUN_W'(1);
      end
    end
  end

  assign pin_outpad   = r_pin;
  assign busy         = (r_state == HOLD);
  assign underrun_cnt = r_underrun;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_gp_outpad_word_driver.sv
// Directed bench for gp_outpad_word_driver: reset, hold timing, back-to-back,
// FIFO fill/drain, enable drop mid-hold and reset mid-hold.
module tb_gp_outpad_word_driver;
  import gp_outpad_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [7:0]  hold_cycles;
  logic [7:0]  idle_value;
  logic [7:0]  pin_outpad;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [7:0]  underrun_cnt;
  drv_state_e  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  gp_outpad_word_driver_if #(.NUM_PADS(8)) in_if ();

  gp_outpad_word_driver dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .in_if        (in_if.slave),
    .hold_cycles  (hold_cycles),
    .idle_value   (idle_value),
    .pin_outpad   (pin_outpad),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .underrun_cnt (underrun_cnt),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; hold_cycles = 8'd0; idle_value = 8'hA5;
    in_if.in_valid = 1'b0; in_if.in_data = 8'h00;
    tick(); tick();
    checks++; if (pin_outpad !== 8'h00) begin failures++; $display("FAIL rst_pin got=%h exp=00", pin_outpad); end
    checks++; if (in_if.in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", in_if.in_ready); end
    checks++; if (busy !== 1'b0 || dbg_state !== IDLE) begin failures++; $display("FAIL rst_busy got=%b/%0d exp=0/IDLE", busy, dbg_state); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
    reset_n = 1'b1;
    tick();
    checks++; if (pin_outpad !== 8'hA5) begin failures++; $display("FAIL rel_pin got=%h exp=a5", pin_outpad); end
    checks++; if (in_if.in_ready !== 1'b1) begin failures++; $display("FAIL rel_ready got=%b exp=1", in_if.in_ready); end
    checks++; if (underrun_cnt !== 8'd0) begin failures++; $display("FAIL rel_underrun got=%0d exp=0", underrun_cnt); end
  endtask

  task automatic test_hold();
    hold_cycles = 8'd3;
    in_if.in_valid = 1'b1; in_if.in_data = 8'h3C;
    tick();
    in_if.in_valid = 1'b0;
    checks++; if (pin_outpad !== 8'hA5) begin failures++; $display("FAIL hold_pre got=%h exp=a5", pin_outpad); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pin_outpad !== 8'h3C || busy !== 1'b1) begin failures++; $display("FAIL hold_word%0d got=%h/%b exp=3c/1", i, pin_outpad, busy); end
    end
    tick();
    checks++; if (pin_outpad !== 8'hA5 || busy !== 1'b0) begin failures++; $display("FAIL hold_end got=%h/%b exp=a5/0", pin_outpad, busy); end
    checks++; if (underrun_cnt !== 8'd1) begin failures++; $display("FAIL hold_underrun got=%0d exp=1", underrun_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    hold_cycles = 8'd0;
    in_if.in_valid = 1'b1;
    in_if.in_data = words[0];
    tick();
    checks++; if (pin_outpad !== 8'hA5) begin failures++; $display("FAIL b2b_pre got=%h exp=a5", pin_outpad); end
    for (int i = 0; i < 3; i++) begin
      if (i < 2) in_if.in_data = words[i+1];
      else in_if.in_valid = 1'b0;
      tick();
      checks++; if (pin_outpad !== words[i]) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", i, pin_outpad, words[i]); end
    end
    tick();
    checks++; if (pin_outpad !== 8'hA5) begin failures++; $display("FAIL b2b_idle got=%h exp=a5", pin_outpad); end
    checks++; if (underrun_cnt !== 8'd2) begin failures++; $display("FAIL b2b_underrun got=%0d exp=2", underrun_cnt); end
  endtask

  task automatic test_fill();
    logic [7:0] exp_w;
    enable = 1'b0; hold_cycles = 8'd0;
    in_if.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_if.in_data = 8'(i * 8'h11);
      exp_q.push_back(8'(i * 8'h11));
      tick();
    end
    checks++; if (in_if.in_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", in_if.in_ready); end
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", fifo_count); end
    in_if.in_data = 8'h55;
    exp_q.push_back(8'h55);
    tick();
    checks++; if (fifo_count !== 3'd4 || pin_outpad !== 8'hA5) begin failures++; $display("FAIL fill_stall got=%0d/%h exp=4/a5", fifo_count, pin_outpad); end
    enable = 1'b1;
    tick();
    exp_w = exp_q.pop_front();
    checks++; if (pin_outpad !== exp_w) begin failures++; $display("FAIL drain0 got=%h exp=%h", pin_outpad, exp_w); end
    checks++; if (in_if.in_ready !== 1'b1 || fifo_count !== 3'd3) begin failures++; $display("FAIL drain_ready got=%b/%0d exp=1/3", in_if.in_ready, fifo_count); end
    tick();
    in_if.in_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      exp_w = exp_q.pop_front();
      checks++; if (pin_outpad !== exp_w) begin failures++; $display("FAIL drain%0d got=%h exp=%h", i, pin_outpad, exp_w); end
      if (i < 4) tick();
    end
    tick();
    checks++; if (pin_outpad !== 8'hA5 || fifo_count !== 3'd0) begin failures++; $display("FAIL drain_end got=%h/%0d exp=a5/0", pin_outpad, fifo_count); end
    checks++; if (underrun_cnt !== 8'd3) begin failures++; $display("FAIL drain_underrun got=%0d exp=3", underrun_cnt); end
  endtask

  task automatic test_enable_drop();
    hold_cycles = 8'd5; enable = 1'b1;
    in_if.in_valid = 1'b1; in_if.in_data = 8'h5A;
    tick();
    in_if.in_valid = 1'b0;
    tick();
    checks++; if (pin_outpad !== 8'h5A) begin failures++; $display("FAIL en_start got=%h exp=5a", pin_outpad); end
    enable = 1'b0; hold_cycles = 8'd0; idle_value = 8'h0F;
    in_if.in_valid = 1'b1; in_if.in_data = 8'h66;
    tick();
    in_if.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (pin_outpad !== 8'h5A || busy !== 1'b1) begin failures++; $display("FAIL en_hold%0d got=%h/%b exp=5a/1", i, pin_outpad, busy); end
      if (i < 4) tick();
    end
    tick();
    checks++; if (pin_outpad !== 8'h0F || busy !== 1'b0) begin failures++; $display("FAIL en_idle got=%h/%b exp=0f/0", pin_outpad, busy); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL en_count got=%0d exp=1", fifo_count); end
    idle_value = 8'hC3;
    tick();
    checks++; if (pin_outpad !== 8'hC3 || fifo_count !== 3'd1) begin failures++; $display("FAIL en_live_idle got=%h/%0d exp=c3/1", pin_outpad, fifo_count); end
    checks++; if (underrun_cnt !== 8'd4) begin failures++; $display("FAIL en_underrun got=%0d exp=4", underrun_cnt); end
  endtask

  task automatic test_reset_mid();
    hold_cycles = 8'd5; enable = 1'b1;
    tick();
    checks++; if (pin_outpad !== 8'h66 || busy !== 1'b1) begin failures++; $display("FAIL rm_start got=%h/%b exp=66/1", pin_outpad, busy); end
    in_if.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_if.in_data = 8'(8'hE0 + i);
      tick();
    end
    in_if.in_valid = 1'b0;
    checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL rm_queued got=%0d exp=3", fifo_count); end
    reset_n = 1'b0;
    tick();
    checks++; if (pin_outpad !== 8'h00 || fifo_count !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL rm_reset got=%h/%0d/%b exp=00/0/0", pin_outpad, fifo_count, busy); end
    checks++; if (underrun_cnt !== 8'd0) begin failures++; $display("FAIL rm_underrun got=%0d exp=0", underrun_cnt); end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pin_outpad !== 8'hC3 || busy !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL rm_after%0d got=%h/%b/%0d exp=c3/0/0", i, pin_outpad, busy, fifo_count); end
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_back_to_back();
    test_fill();
    test_enable_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gp_outpad_word_driver.md
Name: gp_outpad_word_driver

Overview:
- Sequential source stage directly upstream of the bottom-side general-purpose output-pad grid tile.
- Accepts 8-bit pad words over a valid/ready stream and buffers them in a small FIFO.
- Drives each word onto the tile's per-subtile outpad input pins for a programmable number of cycles, then releases the pins to a programmable idle pattern.
- Provides deterministic, cycle-accurate pad waveforms for fabric bring-up and test.

Parameters:
- NUM_PADS, 8, number of outpad subtiles driven; bit k feeds subtile k.
- FIFO_DEPTH, 4, word buffer entries; power of two, at least 2.
- HOLD_W, 8, width of the hold-cycle count.
- UNDERRUN_W, 8, width of the saturating underrun counter.

Ports:
- clk, input, 1, fabric operating clock.
- reset_n, input, 1, reset, synchronous and active-low.
- enable, input, 1, permits popping new words from the FIFO.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, FIFO can accept a word.
- in_data, input, NUM_PADS, pad word; bit k goes to subtile k.
- hold_cycles, input, HOLD_W, extra cycles each word is held; sampled at pop.
- idle_value, input, NUM_PADS, pattern driven when no word is active.
- pin_outpad, output, NUM_PADS, registered; bit k connects to subtile k's outpad_0 pin.
- busy, output, 1, high in HOLD state.
- fifo_count, output, clog2(FIFO_DEPTH)+1, current occupancy.
- underrun_cnt, output, UNDERRUN_W, saturating count of HOLD to IDLE transitions.

Behaviour:
- Clock and reset:
  - Single clock domain, clk only.
  - Reset is synchronous and active-low: it takes effect on the clk rising edge while reset_n=0.
- Reset values:
  - pin_outpad=0, busy=0, fifo_count=0, underrun_cnt=0, in_ready=0 while in reset.
  - FIFO pointers cleared; FSM in IDLE.
  - in_ready rises on the first edge after reset_n=1.
- Input handshake:
  - A push occurs when in_valid and in_ready are both high at a rising edge.
  - in_ready = (fifo_count < FIFO_DEPTH). There is no bypass path.
  - in_data must stay stable while in_valid=1 and in_ready=0.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - A simultaneous push and pop leaves fifo_count unchanged.
  - A pop on empty never occurs.
  - A push while full never occurs, because in_ready is low.
- FSM states: IDLE, HOLD.
  - IDLE: pin_outpad <= idle_value every cycle. If enable=1 and fifo_count>0: pop the head, pin_outpad <= head, cnt <= hold_cycles, go to HOLD.
  - HOLD: pin_outpad holds the popped word; busy=1.
    - If cnt != 0: cnt decrements.
    - If cnt == 0 and enable=1 and the FIFO is non-empty: pop the next word with no gap, reload cnt, stay in HOLD.
    - If cnt == 0 otherwise: go to IDLE, pin_outpad <= idle_value, underrun_cnt increments, saturating at all-ones.
- Latency and timing:
  - A word pushed at edge t into an empty FIFO in IDLE with enable=1 is popped at edge t+1.
  - It appears on pin_outpad after edge t+1 and stays there for hold_cycles+1 cycles.
  - hold_cycles=0 gives a 1-cycle pulse.
  - The maximum hold is 2^HOLD_W cycles.
- enable deasserted mid-HOLD: the current word completes its full hold, then the FSM goes to IDLE. FIFO contents are retained.
- hold_cycles or idle_value changing mid-HOLD: no effect on the current word. idle_value is live while in IDLE.
- Reset mid-operation: FIFO contents are discarded and outputs return to their reset values on the same edge.

Decomposition:
- Shared package gp_outpad_pkg: typedef pad_word_t (logic [NUM_PADS-1:0]), enum drv_state_e {IDLE, HOLD}, default constants for NUM_PADS and FIFO_DEPTH.
- One sub-module, gp_outpad_word_fifo: a synchronous FIFO with push, pop, count, full and empty.
- The top level holds the FSM, the hold counter, the output register and the underrun counter.

Test Plan:
- Reset with idle_value=8'hA5 and enable=1: pin_outpad=8'h00 during reset. It becomes 8'hA5 on the first edge after reset_n=1; in_ready=1 and underrun_cnt=0.
- hold_cycles=3, push 8'h3C: pin_outpad=8'h3C for exactly 4 cycles, starting 1 cycle after the push edge, then 8'hA5. underrun_cnt=1.
- hold_cycles=0, push 8'h01, 8'h02, 8'h03 back-to-back: pin_outpad shows 01,02,03 on consecutive cycles with no idle gap. underrun_cnt increments once.
- enable=0, push 5 words: in_ready drops after the 4th push and fifo_count=4. With enable=1 the words drain in order and in_ready reasserts after the first pop.
- enable dropped during HOLD with hold_cycles=5: the current word still lasts 6 cycles, then idle is driven and fifo_count stays unchanged.
- reset_n=0 mid-HOLD with 3 words queued: pin_outpad=0, fifo_count=0 and busy=0 on the next edge. After release, no stale word appears.
